// File: rtl/sha256_chunk.sv
// Iterative SHA-256 compression: one round per clock, 64 clocks per chunk,
// free-running. data/V_in are sampled only on the round-0 edge.
module sha256_chunk (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] data,
  input  logic [255:0] V_in,
  output logic [255:0] hash
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned NUM_VARS = 8;
  localparam int unsigned RND_W = 6;

  localparam logic [WORD_W-1:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Round counter keeps this exact name so it can be deposited externally.
  logic [RND_W-1:0] roundnum;
  logic [RND_W-1:0] roundnum_d;

  // Working variables a..h in lanes 0..7, schedule window, latched chaining value.
  logic [NUM_VARS-1:0][WORD_W-1:0]  st_q, st_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0] w_q, w_d;
  logic [NUM_VARS-1:0][WORD_W-1:0]  vl_q, vl_d;
  logic [NUM_VARS-1:0][WORD_W-1:0]  hash_q, hash_d;

  logic [NUM_VARS-1:0][WORD_W-1:0]  src_st;
  logic [NUM_WORDS-1:0][WORD_W-1:0] src_w;
  logic [WORD_W-1:0] w_next;
  logic [WORD_W-1:0] t1;
  logic [WORD_W-1:0] t2;
  logic [WORD_W-1:0] ch;
  logic [WORD_W-1:0] maj;
  logic              first_rnd;
  logic              last_rnd;

  // One compression round, schedule expansion and final feed-forward.
  always_comb begin
    roundnum_d = roundnum + RND_W'(1);
    first_rnd  = (roundnum == RND_W'(0));
    last_rnd   = (roundnum == RND_W'(63));

    src_st = first_rnd ? V_in : st_q;
    for (int i = 0; i < NUM_WORDS; i++) begin
      src_w[i] = first_rnd ? {data[32*i +: 8], data[32*i+8 +: 8],
                              data[32*i+16 +: 8], data[32*i+24 +: 8]}
                           : w_q[i];
    end

    w_next = small_sigma1(src_w[14]) + src_w[9] + small_sigma0(src_w[1]) + src_w[0];
    for (int i = 0; i < NUM_WORDS - 1; i++) begin
      w_d[i] = src_w[i+1];
    end
    w_d[NUM_WORDS-1] = w_next;

    ch  = (src_st[4] & src_st[5]) ^ (~src_st[4] & src_st[6]);
    maj = (src_st[0] & src_st[1]) ^ (src_st[0] & src_st[2]) ^ (src_st[1] & src_st[2]);
    t1  = src_st[7] + big_sigma1(src_st[4]) + ch + K_ROM[roundnum] + src_w[0];
    t2  = big_sigma0(src_st[0]) + maj;

    st_d[0] = t1 + t2;
    st_d[1] = src_st[0];
    st_d[2] = src_st[1];
    st_d[3] = src_st[2];
    st_d[4] = src_st[3] + t1;
    st_d[5] = src_st[4];
    st_d[6] = src_st[5];
    st_d[7] = src_st[6];

    vl_d = first_rnd ? V_in : vl_q;

    hash_d = hash_q;
    if (last_rnd) begin
      for (int j = 0; j < NUM_VARS; j++) begin
        hash_d[j] = vl_q[j] + st_d[j];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roundnum <= '0;
      st_q     <= '0;
      w_q      <= '0;
      vl_q     <= '0;
      hash_q   <= '0;
    end else begin
      roundnum <= roundnum_d;
      st_q     <= st_d;
      w_q      <= w_d;
      vl_q     <= vl_d;
      hash_q   <= hash_d;
    end
  end

  assign hash = hash_q;

endmodule

// File: tb/tb_sha256_chunk.sv
// Self-checking bench for sha256_chunk against a plain FIPS 180-4 model.
module tb_sha256_chunk;

  logic         clk;
  logic         rst;
  logic [511:0] data;
  logic [255:0] V_in;
  logic [255:0] hash;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] IV =
    256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;
  localparam logic [255:0] ABC_H =
    256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
  localparam logic [255:0] EMPTY_H =
    256'h7852b855_a495991b_649b934c_27ae41e4_996fb924_9afbf4c8_98fc1c14_e3b0c442;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_chunk dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .V_in (V_in),
    .hash (hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-word schedule, then the standard round loop.
  function automatic logic [255:0] ref_hash(input logic [511:0] d, input logic [255:0] v);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, dd, e, f, g, h, s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++)
      w[i] = {d[8*(4*i) +: 8], d[8*(4*i+1) +: 8], d[8*(4*i+2) +: 8], d[8*(4*i+3) +: 8]};
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int j = 0; j < 8; j++) hv[j] = v[32*j +: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; dd = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = dd + t1; dd = c; c = b; b = a; a = t1 + t2;
    end
    r[31:0]    = hv[0] + a;
    r[63:32]   = hv[1] + b;
    r[95:64]   = hv[2] + c;
    r[127:96]  = hv[3] + dd;
    r[159:128] = hv[4] + e;
    r[191:160] = hv[5] + f;
    r[223:192] = hv[6] + g;
    r[255:224] = hv[7] + h;
    return r;
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand_iv();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  logic [511:0] abc_data;
  logic [511:0] empty_data;
  logic [255:0] last_exp;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data = abc_data;
    V_in = IV;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (hash !== 256'h0) begin
      errors++;
      $display("FAIL reset_async: hash=%h expected 0", hash);
    end
    step(2);
    checks++;
    if (hash !== 256'h0) begin
      errors++;
      $display("FAIL reset_held: hash=%h expected 0", hash);
    end
    rst = 1'b0;
  endtask

  task automatic test_abc();
    step(63);
    checks++;
    if (hash !== 256'h0) begin
      errors++;
      $display("FAIL abc_early: hash=%h expected 0 before edge 64", hash);
    end
    step(1);
    checks++;
    if (hash !== ABC_H) begin
      errors++;
      $display("FAIL abc_hash: hash=%h expected %h", hash, ABC_H);
    end
  endtask

  task automatic test_empty();
    data = empty_data;
    step(63);
    checks++;
    if (hash !== ABC_H) begin
      errors++;
      $display("FAIL empty_hold: hash=%h expected %h", hash, ABC_H);
    end
    step(1);
    checks++;
    if (hash !== EMPTY_H) begin
      errors++;
      $display("FAIL empty_hash: hash=%h expected %h", hash, EMPTY_H);
    end
    last_exp = EMPTY_H;
  endtask

  task automatic test_random();
    logic [255:0] exp;
    for (int k = 0; k < 4; k++) begin
      data = rand_data();
      V_in = rand_iv();
      exp = ref_hash(data, V_in);
      step(63);
      checks++;
      if (hash !== last_exp) begin
        errors++;
        $display("FAIL random_hold[%0d]: hash=%h expected %h", k, hash, last_exp);
      end
      step(1);
      checks++;
      if (hash !== exp) begin
        errors++;
        $display("FAIL random_hash[%0d]: hash=%h expected %h", k, hash, exp);
      end
      last_exp = exp;
    end
  endtask

  task automatic test_isolation();
    logic [255:0] exp;
    data = abc_data;
    V_in = IV;
    step(5);
    data = '1;
    step(59);
    checks++;
    if (hash !== ABC_H) begin
      errors++;
      $display("FAIL iso_abc: hash=%h expected %h", hash, ABC_H);
    end
    exp = ref_hash(data, V_in);
    step(64);
    checks++;
    if (hash !== exp) begin
      errors++;
      $display("FAIL iso_ones: hash=%h expected %h", hash, exp);
    end
    checks++;
    if (hash === ABC_H) begin
      errors++;
      $display("FAIL iso_differs: hash=%h expected a value other than %h", hash, ABC_H);
    end
    last_exp = exp;
  endtask

  task automatic test_deposit();
    data = abc_data;
    V_in = IV;
    dut.roundnum = 6'h3e;
    step(65);
    checks++;
    if (hash === ABC_H) begin
      errors++;
      $display("FAIL deposit_early: hash=%h already abc before edge 66", hash);
    end
    step(1);
    checks++;
    if (hash !== ABC_H) begin
      errors++;
      $display("FAIL deposit_hash: hash=%h expected %h", hash, ABC_H);
    end
    for (int e = 67; e <= 80; e++) begin
      step(1);
      checks++;
      if (hash !== ABC_H) begin
        errors++;
        $display("FAIL deposit_stable[%0d]: hash=%h expected %h", e, hash, ABC_H);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] exp;
    // Realign to a chunk boundary, then run a full abc chunk.
    rst = 1'b1;
    #2 rst = 1'b0;
    data = abc_data;
    V_in = IV;
    step(64);
    checks++;
    if (hash !== ABC_H) begin
      errors++;
      $display("FAIL mid_setup: hash=%h expected %h", hash, ABC_H);
    end
    data = rand_data();
    step(30);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (hash !== 256'h0) begin
      errors++;
      $display("FAIL mid_async_clear: hash=%h expected 0", hash);
    end
    data = rand_data();
    V_in = rand_iv();
    exp = ref_hash(data, V_in);
    step(1);
    rst = 1'b0;
    step(63);
    checks++;
    if (hash !== 256'h0) begin
      errors++;
      $display("FAIL mid_early: hash=%h expected 0", hash);
    end
    step(1);
    checks++;
    if (hash !== exp) begin
      errors++;
      $display("FAIL mid_hash: hash=%h expected %h", hash, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp;
    data = abc_data;
    V_in = IV;
    for (int e = 1; e <= 192; e++) begin
      step(1);
      exp = (e < 64) ? last_exp : ABC_H;
      checks++;
      if (hash !== exp) begin
        errors++;
        $display("FAIL b2b[%0d]: hash=%h expected %h", e, hash, exp);
      end
    end
  endtask

  initial begin
    abc_data = '0;
    abc_data[31:0] = 32'h80636261;
    abc_data[511:504] = 8'h18;
    empty_data = '0;
    empty_data[7:0] = 8'h80;
    last_exp = '0;
    test_reset();
    test_abc();
    test_empty();
    test_random();
    test_isolation();
    test_deposit();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_chunk.md
# sha256_chunk

Iterative SHA-256 compression core: one 512-bit message chunk plus a 256-bit chaining value produce a 256-bit updated hash. One round per clock, 64 clocks per chunk, free-running back-to-back. It sits below the mining/hash control logic, which supplies `data` and `V_in` and reads `hash`. No handshake: the caller tracks the fixed 64-cycle schedule, or forces the round counter.

## Interface
- Parameters: none.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset; one clock; reset is asynchronous and active-high.
- `data` input 512: message chunk, byte-addressed. Message byte k is `data[8k+7:8k]`. Word Wi (big-endian per SHA-256) = {byte 4i, 4i+1, 4i+2, 4i+3}.
- `V_in` input 256: chaining value. Hj is `V_in[32j+31:32j]` as a native 32-bit number (H0 in the LSBs).
- `hash` output 256: registered result, same packing as `V_in`.

## Operation
- Internal 6-bit register `roundnum`, named exactly so. Benches deposit values into it hierarchically.
  - Counts 0..63 and wraps 63 -> 0 every clock, unconditionally.
- State registers:
  - working variables a..h;
  - 16-entry message schedule window W;
  - latched chaining value Vl (256 bits).
- Edge with `roundnum==0`:
  - sample `data` and `V_in` (the only sampling point);
  - Vl <= V_in;
  - compute round 0 with a..h taken combinationally from `V_in` and W0 from `data`;
  - load the window from `data`.
- Edge with `roundnum==t` (1..63):
  - compute round t from the registered a..h;
  - Wt for t>=16 = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16 mod 2^32;
  - the window shifts by one word.
- Round function is standard FIPS 180-4: T1 = h + Σ1(e) + Ch(e,f,g) + Kt + Wt, T2 = Σ0(a) + Maj(a,b,c). All adds are mod 2^32. Kt comes from a 64-entry constant ROM indexed by `roundnum`.
- Edge with `roundnum==63`: `hash` word j <= Vl word j + round-63 result word j (a..h -> H0..H7), mod 2^32 per word.
- `hash` holds its value between updates.
- Input changes while `roundnum`≠0 have no effect on the chunk in flight.

## Timing
- Reset (async assert): `roundnum`=0, a..h=0, W=0, Vl=0, `hash`=0.
- After deassert, the first rising edge is round 0.
- Latency: `hash` updates on the 64th rising edge after the round-0 edge (counting the round-0 edge). Inputs must be valid at that round-0 edge.
- Throughput: one result every 64 clocks. The next chunk's round 0 is the edge immediately after the update edge.
- If `roundnum` is deposited with value n, the next round-0 edge is 64-n edges later, and the update is 63 edges after that.
- Reset mid-chunk aborts the chunk. `hash` returns to 0 and the partial result is discarded.
- No outputs other than `hash`. No done strobe; completion is defined purely by `roundnum`.

## Test plan
- "abc": `data[7:0]`=0x61, `[15:8]`=0x62, `[23:16]`=0x63, `[31:24]`=0x80, `[511:504]`=0x18, rest 0. `V_in`=0x5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667. Reset, then 64 edges.
  - Expect `hash[31:0]`=0xba7816bf ... `hash[255:224]`=0xf20015ad (H = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad).
- Empty message: `data[7:0]`=0x80, rest 0, same IV.
  - Expect H = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Deposit `roundnum`=0x3e with the "abc" stimulus, no reset.
  - Expect the "abc" hash on edge 66. Expect it stable through edge 80.
- Input isolation: change `data` to all-ones on edge 5 of an "abc" chunk.
  - Expect the "abc" hash on edge 64.
  - Expect the next chunk (all-ones data) to complete on edge 128 with a different value.
- Reset mid-operation: assert `rst` asynchronously at cycle 30.
  - Expect `hash`=0 immediately.
  - After deassert, expect a correct hash exactly 64 edges later.
- Back-to-back: hold "abc" inputs for 192 edges.
  - Expect `hash` rewritten with an identical value on edges 64, 128 and 192, constant otherwise.
